exec_ctrl: RTL and testbench
============================

// Module: exec_ctrl
// PURPOSE
//  Run/pause/halt sequencer for the 5-stage MIPS core and its statistic counters.
//  Decodes syscalls retiring in WB ($v0 on A, $a0 on B), drives the global
//  pipeline/statistic enable and latches syscall display output.
//  Adds button-driven resume and single-step, plus a cycle-budget watchdog.
//  Sits between the core's WB stage and the statistic block; cpu_en gates both.
// PARAMETERS
//  MAX_CYCLES   32'hFFFF_FFFF  enabled-cycle budget; reaching it forces HALT (timeout)
//  SYS_HALT     32'd10         $v0 code: terminate
//  SYS_PAUSE    32'd50         $v0 code: pause until go
//  SYS_OUT_A    32'd1          $v0 code: output $a0, keep running
//  SYS_OUT_B    32'd34         $v0 code: output $a0, keep running
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  syscall_t    in   1   syscall instruction in WB this cycle
//  A            in   32  $v0 value accompanying syscall_t
//  B            in   32  $a0 value accompanying syscall_t
//  strong_halt  in   1   external forced stop (level)
//  go           in   1   resume request (level, button, synchronised upstream)
//  step         in   1   single-step request (level, button, synchronised upstream)
//  cpu_en       out  1   pipeline + statistic enable
//  halt         out  1   terminal halt reached
//  timeout      out  1   halt caused by watchdog
//  SyscallOut   out  32  last $a0 output via SYS_OUT_A/SYS_OUT_B
//  out_valid    out  1   one-cycle pulse when SyscallOut updates
//  run_cycles   out  32  count of cycles with cpu_en=1
//  state        out  2   00 RUN, 01 PAUSE, 10 STEP, 11 HALT
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=RUN, SyscallOut=0, run_cycles=0, out_valid=0,
//    timeout=0, edge-detect regs=0. cpu_en forced 0 while rst=1.
//  - cpu_en = !rst & (state==RUN | state==STEP), combinational; halt = (state==HALT).
//  - go/step edge-detected internally: action only on 0->1; a held level never repeats.
//  - syscall_t honoured only when cpu_en=1; ignored otherwise.
//  - A syscall retiring in cycle N completes in N; the state change shows in N+1.
//  - Transition priority, evaluated every cycle (highest first):
//    1 strong_halt=1                          -> HALT (any state)
//    2 cpu_en & syscall_t & A==SYS_HALT       -> HALT
//    3 cpu_en & run_cycles==MAX_CYCLES-1      -> HALT, timeout<=1
//    4 cpu_en & syscall_t & A==SYS_PAUSE      -> PAUSE
//    5 STEP                                   -> PAUSE (STEP lasts exactly 1 cycle)
//    6 PAUSE & go rising                      -> RUN
//    7 PAUSE & step rising                    -> STEP (go wins if both rise together)
//    else hold.
//  - HALT is terminal; only rst leaves it. go/step are ignored in RUN and HALT.
//  - Output syscall (A==SYS_OUT_A or SYS_OUT_B, cpu_en=1): SyscallOut<=B,
//    out_valid=1 for the next cycle only. Also applies to a STEP cycle.
//    Other unknown $v0 codes: no-op.
//  - run_cycles += 1 each cycle cpu_en=1; saturates at MAX_CYCLES, never wraps.
//  - Watchdog cycle and halt syscall in the same cycle: HALT, timeout=0.
//  - rst mid-operation (any state): next cycle RUN, all counters/outputs cleared.
// TESTING
//  1 rst 5 cycles, release -> cycle 1 after: state=00, cpu_en=1; run_cycles=10 after 10 cycles.
//  2 syscall_t=1,A=34,B=123 -> next cycle SyscallOut=123, out_valid=1 for 1 cycle, still RUN.
//  3 syscall_t=1,A=50 -> state=PAUSE, cpu_en=0; hold step=1 for 5 cycles -> exactly 1 cpu_en cycle, run_cycles+1.
//  4 In PAUSE, go rises -> RUN next cycle; then syscall A=10 -> halt=1; go/step ignored until rst.
//  5 MAX_CYCLES=20 -> after 20 enabled cycles halt=1, timeout=1, run_cycles=20 stays.
//  6 strong_halt=1 with simultaneous syscall A=34 -> HALT, SyscallOut still updates to B.

Source files
------------

// File: rtl/exec_ctrl.sv
// exec_ctrl: run/pause/step/halt sequencer for the 5-stage MIPS core.
// Decodes syscalls retiring in WB ($v0 on A, $a0 on B), drives the global
// pipeline/statistic enable, latches syscall display output, supports
// button resume / single-step and halts on an enabled-cycle watchdog.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          synchronous active-high reset
//   syscall_t    syscall instruction in WB this cycle
//   A, B         $v0 / $a0 values accompanying syscall_t
//   strong_halt  external forced stop (level)
//   go, step     resume / single-step buttons (levels, edge-detected here)
//   cpu_en       pipeline + statistic enable
//   halt         terminal halt reached
//   timeout      halt was caused by the watchdog
//   SyscallOut   last $a0 printed by an output syscall
//   out_valid    one-cycle pulse when SyscallOut updates
//   run_cycles   number of cycles with cpu_en=1 (saturating)
//   state        00 RUN, 01 PAUSE, 10 STEP, 11 HALT
module exec_ctrl #(
  parameter logic [31:0] MAX_CYCLES = 32'hFFFF_FFFF,
  parameter logic [31:0] SYS_HALT   = 32'd10,
  parameter logic [31:0] SYS_PAUSE  = 32'd50,
  parameter logic [31:0] SYS_OUT_A  = 32'd1,
  parameter logic [31:0] SYS_OUT_B  = 32'd34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall_t,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        strong_halt,
  input  logic        go,
  input  logic        step,
  output logic        cpu_en,
  output logic        halt,
  output logic        timeout,
  output logic [31:0] SyscallOut,
  output logic        out_valid,
  output logic [31:0] run_cycles,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StPause = 2'b01,
    StStep  = 2'b10,
    StHalt  = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic        go_q, step_q;
  logic        timeout_q, timeout_d;
  logic [31:0] out_q, out_d;
  logic        valid_q, valid_d;
  logic [31:0] cycles_q, cycles_d;

  logic go_rise, step_rise;
  logic sys_halt, sys_pause, sys_out, watchdog;

  assign cpu_en = !rst && ((state_q == StRun) || (state_q == StStep));

  assign go_rise   = go & ~go_q;
  assign step_rise = step & ~step_q;

  assign sys_halt  = cpu_en && syscall_t && (A == SYS_HALT);
  assign sys_pause = cpu_en && syscall_t && (A == SYS_PAUSE);
  assign sys_out   = cpu_en && syscall_t && ((A == SYS_OUT_A) || (A == SYS_OUT_B));
  // Last enabled cycle within the budget: the count reaches MAX_CYCLES at this edge.
  assign watchdog  = cpu_en && (cycles_q == (MAX_CYCLES - 32'd1));

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    cycles_d  = cycles_q;

    if (strong_halt) begin
      state_d = StHalt;
    end else if (sys_halt) begin
      // A halt syscall coinciding with the watchdog is a clean halt, not a timeout.
      state_d = StHalt;
    end else if (watchdog) begin
      state_d   = StHalt;
      timeout_d = 1'b1;
    end else if (sys_pause) begin
      state_d = StPause;
    end else if (state_q == StStep) begin
      state_d = StPause;
    end else if ((state_q == StPause) && go_rise) begin
      state_d = StRun;
    end else if ((state_q == StPause) && step_rise) begin
      state_d = StStep;
    end

    // Output syscalls complete even when the state change is overridden.
    if (sys_out) begin
      out_d   = B;
      valid_d = 1'b1;
    end

    if (cpu_en && (cycles_q != MAX_CYCLES)) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      go_q      <= 1'b0;
      step_q    <= 1'b0;
      timeout_q <= 1'b0;
      out_q     <= 32'd0;
      valid_q   <= 1'b0;
      cycles_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      go_q      <= go;
      step_q    <= step;
      timeout_q <= timeout_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      cycles_q  <= cycles_d;
    end
  end

  assign halt       = (state_q == StHalt);
  assign timeout    = timeout_q;
  assign SyscallOut = out_q;
  assign out_valid  = valid_q;
  assign run_cycles = cycles_q;
  assign state      = state_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed scenarios followed by random episodes, all
// checked cycle by cycle against a behavioural model of the sequencer.
module tb_exec_ctrl;

  localparam int unsigned MaxCyc = 20;
  localparam int MRun = 0, MPause = 1, MStep = 2, MHalt = 3;

  logic        clk = 1'b0;
  logic        rst, syscall_t, strong_halt, go, step;
  logic [31:0] A, B;
  logic        cpu_en, halt, timeout, out_valid;
  logic [31:0] SyscallOut, run_cycles;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  // Reference model
  int          m_state = MRun;
  logic [31:0] m_out = 0;
  bit          m_valid = 0;
  int unsigned m_cycles = 0;
  bit          m_timeout = 0;
  bit          m_go_prev = 0, m_step_prev = 0;
  bit          last_en;

  exec_ctrl #(.MAX_CYCLES(32'(MaxCyc))) dut (
    .clk        (clk),
    .rst        (rst),
    .syscall_t  (syscall_t),
    .A          (A),
    .B          (B),
    .strong_halt(strong_halt),
    .go         (go),
    .step       (step),
    .cpu_en     (cpu_en),
    .halt       (halt),
    .timeout    (timeout),
    .SyscallOut (SyscallOut),
    .out_valid  (out_valid),
    .run_cycles (run_cycles),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check the combinational enable, advance the
  // model, then check every registered output after the edge.
  task automatic tick(input bit r, input bit sc, input logic [31:0] a, input logic [31:0] b,
                      input bit sh, input bit g, input bit s);
    bit en, grise, srise;
    int nstate;
    rst = r; syscall_t = sc; A = a; B = b; strong_halt = sh; go = g; step = s;
    #1;
    en = !r && (m_state == MRun || m_state == MStep);
    last_en = en;
    chk("cpu_en", 32'(cpu_en), 32'(en));
    if (r) begin
      m_state = MRun; m_out = 0; m_valid = 0; m_cycles = 0; m_timeout = 0;
      m_go_prev = 0; m_step_prev = 0;
    end else begin
      grise  = g && !m_go_prev;
      srise  = s && !m_step_prev;
      nstate = m_state;
      if (sh) nstate = MHalt;
      else if (en && sc && a == 10) nstate = MHalt;
      else if (en && m_cycles == MaxCyc - 1) begin nstate = MHalt; m_timeout = 1; end
      else if (en && sc && a == 50) nstate = MPause;
      else if (m_state == MStep) nstate = MPause;
      else if (m_state == MPause && grise) nstate = MRun;
      else if (m_state == MPause && srise) nstate = MStep;
      m_valid = en && sc && (a == 1 || a == 34);
      if (m_valid) m_out = b;
      if (en && m_cycles < MaxCyc) m_cycles++;
      m_state = nstate;
      m_go_prev = g; m_step_prev = s;
    end
    @(posedge clk);
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("halt", 32'(halt), 32'(m_state == MHalt));
    chk("timeout", 32'(timeout), 32'(m_timeout));
    chk("SyscallOut", SyscallOut, m_out);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("run_cycles", run_cycles, m_cycles);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0, 0);
  endtask

  int en_count;
  logic [31:0] codes [5] = '{32'd1, 32'd34, 32'd10, 32'd50, 32'd7};

  initial begin
    @(posedge clk);
    #1;
    // Reset and free run
    do_reset(5);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_cycles", run_cycles, 32'd0);
    idle(10);
    chk("run10", run_cycles, 32'd10);

    // Output syscall
    tick(0, 1, 34, 123, 0, 0, 0);
    chk("out_123", SyscallOut, 32'd123);
    chk("out_run", 32'(state), 32'd0);
    idle(1);
    chk("out_pulse_end", 32'(out_valid), 32'd0);

    // Pause, then a held step gives exactly one enabled cycle
    tick(0, 1, 50, 0, 0, 0, 0);
    chk("paused", 32'(state), 32'd1);
    en_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 0, 0, 1);
      en_count += int'(last_en);
    end
    chk("step_once", 32'(en_count), 32'd1);
    chk("step_cycles", run_cycles, 32'd14);
    tick(0, 0, 0, 0, 0, 0, 0);

    // Resume, halt, buttons ignored afterwards
    tick(0, 0, 0, 0, 0, 1, 0);
    chk("resumed", 32'(state), 32'd0);
    tick(0, 1, 10, 0, 0, 0, 0);
    chk("halted", 32'(halt), 32'd1);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    chk("halt_sticky", 32'(state), 32'd3);

    // Watchdog
    do_reset(1);
    idle(20);
    chk("wd_halt", 32'(halt), 32'd1);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_cycles", run_cycles, 32'd20);
    idle(3);
    chk("wd_cycles_hold", run_cycles, 32'd20);

    // Watchdog coinciding with halt syscall: clean halt
    do_reset(1);
    idle(19);
    tick(0, 1, 10, 0, 0, 0, 0);
    chk("wd_sys_halt", 32'(halt), 32'd1);
    chk("wd_sys_timeout", 32'(timeout), 32'd0);

    // strong_halt with simultaneous output syscall
    do_reset(2);
    idle(1);
    tick(0, 1, 34, 77, 1, 0, 0);
    chk("sh_halt", 32'(state), 32'd3);
    chk("sh_out", SyscallOut, 32'd77);
    chk("sh_valid", 32'(out_valid), 32'd1);

    // Random episodes
    for (int e = 0; e < 40; e++) begin
      do_reset(1);
      for (int i = 0; i < 40; i++) begin
        tick(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 3) == 0),
             codes[$urandom_range(0, 4)],
             $urandom,
             ($urandom_range(0, 79) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
